// File: rtl/marker_overlay.sv
// Crosshair overlay at the video output: draws a marker centred on the per-frame
// latched centroid and delays de/hsync/vsync/pixel by one clock so they stay aligned.
//  state      | meaning
//  WAIT_FRAME | no frame start seen since reset; video passes through untouched
//  ACTIVE     | frame timing known; marker drawn when enabled and in range
module marker_overlay #(
  parameter int          IMG_W  = 64,
  parameter int          IMG_H  = 64,
  parameter int          ARM    = 4,
  parameter logic [23:0] COLOUR = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out
);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] W_MAX   = 12'(IMG_W);
  localparam logic [11:0] H_MAX   = 12'(IMG_H);
  localparam logic [12:0] ARM_LEN = 13'(ARM);

  state_t      state_q, state_d;
  logic        vsync_d, de_d;
  logic        vs_rise, de_fall;
  logic [11:0] col, row, mx, my;
  logic        mark_en;
  logic        xy_valid;
  logic signed [12:0] dc, dr;
  logic [12:0] ac, ar;
  logic        hit;

  assign vs_rise  = vsync & ~vsync_d;
  assign de_fall  = ~de & de_d;
  assign xy_valid = (x >= 12'd1) && (x <= W_MAX) && (y >= 12'd1) && (y <= H_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_FRAME && vs_rise) state_d = ACTIVE;
  end

  // 13-bit signed distances so arms near the image edges clip rather than wrap
  always_comb begin
    dc  = $signed({1'b0, col}) - $signed({1'b0, mx});
    dr  = $signed({1'b0, row}) - $signed({1'b0, my});
    ac  = dc[12] ? $unsigned(-dc) : $unsigned(dc);
    ar  = dr[12] ? $unsigned(-dr) : $unsigned(dr);
    hit = mark_en && (state_q == ACTIVE) && de &&
          (((col == mx) && (ar <= ARM_LEN)) || ((row == my) && (ac <= ARM_LEN)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d   <= 1'b0;
      de_d      <= 1'b0;
      col       <= 12'd1;
      row       <= 12'd1;
      mx        <= 12'd0;
      my        <= 12'd0;
      mark_en   <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= 24'd0;
    end else begin
      vsync_d <= vsync;
      de_d    <= de;
      // frame start takes priority over a coincident line end
      if (vs_rise) begin
        col     <= 12'd1;
        row     <= 12'd1;
        mx      <= x;
        my      <= y;
        mark_en <= en & xy_valid;
      end else if (de_fall) begin
        col <= 12'd1;
        if (row != CNT_MAX) row <= row + 12'd1;
      end else if (de && col != CNT_MAX) begin
        col <= col + 12'd1;
      end
      de_out    <= de;
      hsync_out <= hsync;
      vsync_out <= vsync;
      pixel_out <= hit ? COLOUR : pixel_in;
    end
  end

endmodule

// File: tb/tb_marker_overlay.sv
// Bench for marker_overlay: directed frames with random pixel data, checked cycle by
// cycle against a coordinate-level model of where the crosshair belongs.
module tb_marker_overlay;
  localparam int          ARM    = 4;
  localparam logic [23:0] COLOUR = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [11:0] x = '0, y = '0;
  logic        de = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        de_out, hsync_out, vsync_out;
  logic [23:0] pixel_out;

  marker_overlay #(.IMG_W(64), .IMG_H(64), .ARM(ARM), .COLOUR(COLOUR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y),
    .de(de), .hsync(hsync), .vsync(vsync), .pixel_in(pixel_in),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ccount = 0;

  // model state: marker latched at the last frame start
  int  mxl = 0, myl = 0;
  bit  mvalid = 0, active = 0, vs_prev = 0, have_prev = 0;
  bit  pd, ph, pv;
  logic [23:0] pp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit hit(input int c, input int r);
    if (!(mvalid && active)) return 1'b0;
    return ((c == mxl) && (iabs(r - myl) <= ARM)) || ((r == myl) && (iabs(c - mxl) <= ARM));
  endfunction

  // one clock: check last cycle's expectations, then drive new inputs
  task automatic drive(input bit d, input bit h, input bit v, input bit hh);
    logic [23:0] p;
    p = 24'($urandom) & 24'h7FFFFF;
    @(posedge clk); #1;
    if (have_prev) begin
      chk("de_out", 32'(de_out), 32'(pd));
      chk("hsync_out", 32'(hsync_out), 32'(ph));
      chk("vsync_out", 32'(vsync_out), 32'(pv));
      chk("pixel_out", 32'(pixel_out), 32'(pp));
      if (de_out === 1'b1 && pixel_out === COLOUR) ccount++;
    end
    de = d; hsync = h; vsync = v; pixel_in = p;
    pd = d; ph = h; pv = v; pp = hh ? COLOUR : p;
    have_prev = 1;
    if (v && !vs_prev) begin
      mxl = int'(x); myl = int'(y);
      mvalid = en && (x >= 12'd1) && (x <= 12'd64) && (y >= 12'd1) && (y <= 12'd64);
      active = 1;
    end
    vs_prev = v;
  endtask

  task automatic line(input int r, input int npix);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    for (int c = 1; c <= npix; c++) drive(1, 0, 0, hit(c, r));
  endtask

  task automatic frame(input int x0, input int y0, input int x1, input int y1,
                       input int chg, input bit e);
    x = 12'(x0); y = 12'(y0); en = e;
    ccount = 0;
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    for (int r = 1; r <= 64; r++) begin
      if (r == chg) begin x = 12'(x1); y = 12'(y1); end
      line(r, 64);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_de"}, 32'(de_out), 0);
    chk({tag, "_hs"}, 32'(hsync_out), 0);
    chk({tag, "_vs"}, 32'(vsync_out), 0);
    chk({tag, "_pix"}, 32'(pixel_out), 0);
  endtask

  initial begin
    // T1: reset state, then pass-through before any frame start
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    x = 12'd1; y = 12'd1; en = 1'b1;
    for (int c = 1; c <= 20; c++) drive(1, 0, 0, hit(c, 1));
    drive(0, 0, 0, 0);

    // T2: centred marker
    frame(32, 32, 32, 32, 0, 1);
    chk("t2_count", 32'(ccount), 17);

    // reset mid-line with de high, then no marker until a new frame start
    x = 12'd32; y = 12'd32; en = 1'b1;
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    for (int r = 1; r <= 31; r++) line(r, 64);
    line(32, 30);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    have_prev = 0; active = 0; mvalid = 0;
    ccount = 0;
    for (int r = 1; r <= 33; r++) line(r, 64);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("after_reset_count", 32'(ccount), 0);

    // T3: corner clip
    frame(1, 1, 1, 1, 0, 1);
    chk("t3_count", 32'(ccount), 9);

    // T5: centroid moves mid-frame; marker follows only on the next frame
    frame(10, 10, 50, 50, 20, 1);
    chk("t5_count_a", 32'(ccount), 17);
    frame(50, 50, 50, 50, 0, 1);
    chk("t5_count_b", 32'(ccount), 17);

    // T4: no object, then disabled
    frame(0, 10, 0, 10, 0, 1);
    chk("t4_count_x0", 32'(ccount), 0);
    frame(20, 20, 20, 20, 0, 0);
    chk("t4_count_dis", 32'(ccount), 0);

    // T6: random sync/de pattern with the marker disabled
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    drive(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
